// File: rtl/instruction_encoder.sv
// Two-stage valid/ready encoder: packs RV32I fields into an instruction word for patch writes.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instruction_encoder (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [2:0]  imm_type_in,
  input  logic [31:0] imm_in,
  input  logic [6:0]  opcode_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rs1_in,
  input  logic [4:0]  rs2_in,
  input  logic [6:0]  funct7_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [31:0] instr_out,
  output logic        err_out
);

  localparam logic [2:0] TYPE_R = 3'b000;
  localparam logic [2:0] TYPE_S = 3'b010;
  localparam logic [2:0] TYPE_B = 3'b011;
  localparam logic [2:0] TYPE_U = 3'b100;
  localparam logic [2:0] TYPE_J = 3'b101;

  logic        s1_v_d, s1_v_q;
  logic [2:0]  s1_type_d, s1_type_q;
  logic [31:0] s1_imm_d, s1_imm_q;
  logic [6:0]  s1_opc_d, s1_opc_q;
  logic [4:0]  s1_rd_d, s1_rd_q;
  logic [2:0]  s1_f3_d, s1_f3_q;
  logic [4:0]  s1_rs1_d, s1_rs1_q;
  logic [4:0]  s1_rs2_d, s1_rs2_q;
  logic [6:0]  s1_f7_d, s1_f7_q;

  logic        s2_v_d, s2_v_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] fmt_word;

  logic s2_adv;
  logic in_xfer;

  // S2 can accept whenever it is empty or its word leaves this cycle.
  assign s2_adv    = s1_v_q && (!s2_v_q || ready_in);
  assign ready_out = !s1_v_q || s2_adv;
  assign in_xfer   = valid_in && ready_out;

  always_comb begin
    fmt_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
    case (s1_type_q)
      TYPE_R: fmt_word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
      TYPE_S: fmt_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:0], s1_opc_q};
      TYPE_B: fmt_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                          s1_imm_q[4:1], s1_imm_q[11], s1_opc_q};
      TYPE_U: fmt_word = {s1_imm_q[31:12], s1_rd_q, s1_opc_q};
      TYPE_J: fmt_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                          s1_rd_q, s1_opc_q};
      default: fmt_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
    endcase
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_type_d = s1_type_q;
    s1_imm_d  = s1_imm_q;
    s1_opc_d  = s1_opc_q;
    s1_rd_d   = s1_rd_q;
    s1_f3_d   = s1_f3_q;
    s1_rs1_d  = s1_rs1_q;
    s1_rs2_d  = s1_rs2_q;
    s1_f7_d   = s1_f7_q;
    if (in_xfer) begin
      s1_v_d    = 1'b1;
      s1_type_d = imm_type_in;
      s1_imm_d  = imm_in;
      s1_opc_d  = opcode_in;
      s1_rd_d   = rd_in;
      s1_f3_d   = funct3_in;
      s1_rs1_d  = rs1_in;
      s1_rs2_d  = rs2_in;
      s1_f7_d   = funct7_in;
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    s2_v_d  = s2_adv || (s2_v_q && !ready_in);
    instr_d = s2_adv ? fmt_word : instr_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_v_q    <= 1'b0;
      s1_type_q <= 3'b0;
      s1_imm_q  <= 32'b0;
      s1_opc_q  <= 7'b0;
      s1_rd_q   <= 5'b0;
      s1_f3_q   <= 3'b0;
      s1_rs1_q  <= 5'b0;
      s1_rs2_q  <= 5'b0;
      s1_f7_q   <= 7'b0;
      s2_v_q    <= 1'b0;
      instr_q   <= 32'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_type_q <= s1_type_d;
      s1_imm_q  <= s1_imm_d;
      s1_opc_q  <= s1_opc_d;
      s1_rd_q   <= s1_rd_d;
      s1_f3_q   <= s1_f3_d;
      s1_rs1_q  <= s1_rs1_d;
      s1_rs2_q  <= s1_rs2_d;
      s1_f7_q   <= s1_f7_d;
      s2_v_q    <= s2_v_d;
      instr_q   <= instr_d;
    end
  end

  assign valid_out = s2_v_q;
  assign instr_out = instr_q;

`ifdef ENC_RANGE_CHECK_EN
  logic fmt_err;
  logic err_d, err_q;

  // Flags immediates whose significant bits do not survive truncation into the field.
  always_comb begin
    fmt_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
    case (s1_type_q)
      TYPE_R: fmt_err = 1'b0;
      TYPE_B: fmt_err = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
      TYPE_U: fmt_err = |s1_imm_q[11:0];
      TYPE_J: fmt_err = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) || s1_imm_q[0];
      default: fmt_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
    endcase
  end

  always_comb begin
    err_d = s2_adv ? fmt_err : err_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule
